// File: rtl/bcd_run_ctrl.sv
// Run/pause/clear controller for a cascaded BCD digit chain: prescaled Trigger ticks, DigitClear pulse, sticky Overflow.
// Optional feature macro BCD_RUN_CTRL_AUTOSTOP_EN: an overflow moves RUN->DONE and halts ticks until Clear.
module bcd_run_ctrl #(
    parameter int TICK_DIV = 100000000,
    parameter int CNT_W    = 27
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Clear,
    input  logic       ChainCout,
    output logic       Trigger,
    output logic       DigitClear,
    output logic       Running,
    output logic       Overflow,
    output logic [1:0] State
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_prev_q, stop_prev_q, clear_prev_q;
    logic             trigger_q, trigger_d;
    logic             dclr_q, dclr_d;
    logic             running_q, running_d;
    logic             overflow_q, overflow_d;

    logic start_e, stop_e, clear_e, ovf_evt;

    always_comb begin
        start_e    = Start & ~start_prev_q;
        stop_e     = Stop & ~stop_prev_q;
        clear_e    = Clear & ~clear_prev_q;
        ovf_evt    = trigger_q & ChainCout;

        state_d    = state_q;
        cnt_d      = cnt_q;
        trigger_d  = 1'b0;
        dclr_d     = clear_e;
        overflow_d = overflow_q | ovf_evt;

        if (clear_e) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_e) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    // A pause on the terminal count holds the prescaler so the tick lands right after resume
                    if (stop_e) begin
                        state_d = ST_PAUSE;
                    end else if (cnt_q == TERM) begin
                        cnt_d     = '0;
                        trigger_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`ifdef BCD_RUN_CTRL_AUTOSTOP_EN
                    if (ovf_evt) begin
                        state_d   = ST_DONE;
                        cnt_d     = cnt_q;
                        trigger_d = 1'b0;
                    end
`endif
                end
                ST_PAUSE: begin
                    if (start_e) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            clear_prev_q <= 1'b0;
            trigger_q    <= 1'b0;
            dclr_q       <= 1'b0;
            running_q    <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_prev_q <= Start;
            stop_prev_q  <= Stop;
            clear_prev_q <= Clear;
            trigger_q    <= trigger_d;
            dclr_q       <= dclr_d;
            running_q    <= running_d;
            overflow_q   <= overflow_d;
        end
    end

    assign Trigger    = trigger_q;
    assign DigitClear = dclr_q;
    assign Running    = running_q;
    assign Overflow   = overflow_q;
    assign State      = state_q;

endmodule

// File: tb/tb_bcd_run_ctrl.sv
// Directed bench for bcd_run_ctrl with TICK_DIV=4; define BCD_RUN_CTRL_AUTOSTOP_EN for the auto-stop build.
module tb_bcd_run_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0, Stop = 1'b0, Clear = 1'b0, ChainCout = 1'b0;
    logic       Trigger, DigitClear, Running, Overflow;
    logic [1:0] State;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    bcd_run_ctrl #(.TICK_DIV(4), .CNT_W(3)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Clear(Clear),
        .ChainCout(ChainCout), .Trigger(Trigger), .DigitClear(DigitClear),
        .Running(Running), .Overflow(Overflow), .State(State)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_trig();
        int n = 0;
        while (Trigger !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({Trigger, DigitClear, Running, Overflow, State} !== 6'b0) begin
            bad++; $display("FAIL reset_outputs: got %b want 000000", {Trigger, DigitClear, Running, Overflow, State});
        end
        Reset = 1'b1;
        tick(); tick();
        total++;
        if (State !== 2'b00 || Trigger !== 1'b0) begin
            bad++; $display("FAIL reset_idle: state %b trig %b want 00 0", State, Trigger);
        end
    endtask

    task automatic test_run();
        int errs = 0;
        int cnt = 0;
        Start = 1'b1;
        tick();
        total++;
        if (Running !== 1'b1 || State !== 2'b01) begin
            bad++; $display("FAIL run_enter: running %b state %b want 1 01", Running, State);
        end
        Start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (Trigger !== 1'b0) errs++;
        end
        tick();
        total++;
        if (Trigger !== 1'b1 || errs != 0) begin
            bad++; $display("FAIL run_first_tick: trig %b early %0d want 1 0", Trigger, errs);
        end
        errs = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (Trigger !== ((i % 4) == 0)) errs++;
            if (Trigger === 1'b1) cnt++;
        end
        total++;
        if (errs != 0 || cnt != 10) begin
            bad++; $display("FAIL run_period: misplaced %0d pulses %0d want 0 10", errs, cnt);
        end
    endtask

    task automatic test_pause();
        int errs = 0;
        tick(); tick();
        Stop = 1'b1;
        tick();
        total++;
        if (State !== 2'b10 || Trigger !== 1'b0 || Running !== 1'b0) begin
            bad++; $display("FAIL pause_enter: state %b trig %b run %b want 10 0 0", State, Trigger, Running);
        end
        Stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Trigger !== 1'b0 || State !== 2'b10) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL pause_hold: bad cycles %0d want 0", errs);
        end
        Start = 1'b1;
        tick();
        total++;
        if (State !== 2'b01 || Trigger !== 1'b0) begin
            bad++; $display("FAIL pause_resume: state %b trig %b want 01 0", State, Trigger);
        end
        Start = 1'b0;
        tick();
        errs = (Trigger !== 1'b0) ? 1 : 0;
        tick();
        total++;
        if (Trigger !== 1'b1 || errs != 0) begin
            bad++; $display("FAIL pause_resume_tick: trig %b early %0d want 1 0", Trigger, errs);
        end
    endtask

    task automatic test_stop_terminal();
        tick(); tick(); tick();
        Stop = 1'b1;
        tick();
        total++;
        if (Trigger !== 1'b0 || State !== 2'b10) begin
            bad++; $display("FAIL stop_terminal: trig %b state %b want 0 10", Trigger, State);
        end
        Stop = 1'b0;
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        total++;
        if (Trigger !== 1'b1 || State !== 2'b01) begin
            bad++; $display("FAIL stop_terminal_resume: trig %b state %b want 1 01", Trigger, State);
        end
    endtask

    task automatic test_clear();
        Start = 1'b1;
        tick();
        Stop = 1'b1;
        Clear = 1'b1;
        tick();
        total++;
        if (State !== 2'b00 || DigitClear !== 1'b1 || Running !== 1'b0 || Overflow !== 1'b0 || Trigger !== 1'b0) begin
            bad++; $display("FAIL clear_apply: state %b dclr %b run %b ovf %b trig %b want 00 1 0 0 0",
                            State, DigitClear, Running, Overflow, Trigger);
        end
        Stop = 1'b0;
        Clear = 1'b0;
        tick();
        total++;
        if (DigitClear !== 1'b0 || State !== 2'b00) begin
            bad++; $display("FAIL clear_pulse_width: dclr %b state %b want 0 00", DigitClear, State);
        end
        Start = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        int cnt = 0;
        int errs = 0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_trig();
        ChainCout = 1'b1;
        tick();
        ChainCout = 1'b0;
        total++;
        if (Overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_set: got %b want 1", Overflow);
        end
`ifdef BCD_RUN_CTRL_AUTOSTOP_EN
        total++;
        if (State !== 2'b11 || Running !== 1'b0) begin
            bad++; $display("FAIL ovf_done: state %b run %b want 11 0", State, Running);
        end
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (Trigger === 1'b1) cnt++;
            if (State !== 2'b11) errs++;
        end
        total++;
        if (cnt != 0 || errs != 0) begin
            bad++; $display("FAIL ovf_done_silent: pulses %0d bad states %0d want 0 0", cnt, errs);
        end
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        total++;
        if (State !== 2'b00 || Overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_done_clear: state %b ovf %b want 00 0", State, Overflow);
        end
`else
        total++;
        if (State !== 2'b01) begin
            bad++; $display("FAIL ovf_keep_run: state %b want 01", State);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Trigger === 1'b1) cnt++;
        end
        total++;
        if (cnt != 1 || Overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_continue: pulses %0d ovf %b want 1 1", cnt, Overflow);
        end
        wait_trig();
        ChainCout = 1'b1;
        Clear = 1'b1;
        tick();
        ChainCout = 1'b0;
        Clear = 1'b0;
        total++;
        if (Overflow !== 1'b0 || State !== 2'b00) begin
            bad++; $display("FAIL ovf_clear_wins: ovf %b state %b want 0 00", Overflow, State);
        end
`endif
        tick();
    endtask

    task automatic test_hold_start();
        int cnt = 0;
        int errs = 0;
        Start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (State !== 2'b01) errs++;
            if (Trigger === 1'b1) cnt++;
        end
        Start = 1'b0;
        total++;
        if (errs != 0 || cnt != 4) begin
            bad++; $display("FAIL hold_start: bad states %0d pulses %0d want 0 4", errs, cnt);
        end
    endtask

    task automatic test_async_reset();
        int errs = 0;
        wait_trig();
        total++;
        if (Trigger !== 1'b1) begin
            bad++; $display("FAIL areset_setup: trig %b want 1", Trigger);
        end
        #2 Reset = 1'b0;
        #1;
        total++;
        if ({Trigger, DigitClear, Running, Overflow, State} !== 6'b0) begin
            bad++; $display("FAIL areset_immediate: got %b want 000000", {Trigger, DigitClear, Running, Overflow, State});
        end
        #3 Reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (Trigger !== 1'b0 || State !== 2'b00) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL areset_after: bad cycles %0d want 0", errs);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause();
        test_stop_terminal();
        test_clear();
        test_overflow();
        test_hold_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
